// File: rtl/hex_scan_pkg.sv
// Shared definitions for the seven-segment scan driver: scan FSM states,
// the native segment width and active-high glyphs for hex digits 0-F.
package hex_scan_pkg;

    // Scan sequencer states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        BLANK = 2'd1,
        SHOW  = 2'd2
    } scan_state_e;

    // Segments in a standard seven-segment digit (a..g).
    localparam int HEX_SEG_W = 7;

    // Active-high glyphs, bit0 = segment a ... bit6 = segment g.
    localparam logic [HEX_SEG_W-1:0] GLYPH_0 = 7'h3F;
    localparam logic [HEX_SEG_W-1:0] GLYPH_1 = 7'h06;
    localparam logic [HEX_SEG_W-1:0] GLYPH_2 = 7'h5B;
    localparam logic [HEX_SEG_W-1:0] GLYPH_3 = 7'h4F;
    localparam logic [HEX_SEG_W-1:0] GLYPH_4 = 7'h66;
    localparam logic [HEX_SEG_W-1:0] GLYPH_5 = 7'h6D;
    localparam logic [HEX_SEG_W-1:0] GLYPH_6 = 7'h7D;
    localparam logic [HEX_SEG_W-1:0] GLYPH_7 = 7'h07;
    localparam logic [HEX_SEG_W-1:0] GLYPH_8 = 7'h7F;
    localparam logic [HEX_SEG_W-1:0] GLYPH_9 = 7'h6F;
    localparam logic [HEX_SEG_W-1:0] GLYPH_A = 7'h77;
    localparam logic [HEX_SEG_W-1:0] GLYPH_B = 7'h7C;
    localparam logic [HEX_SEG_W-1:0] GLYPH_C = 7'h39;
    localparam logic [HEX_SEG_W-1:0] GLYPH_D = 7'h5E;
    localparam logic [HEX_SEG_W-1:0] GLYPH_E = 7'h79;
    localparam logic [HEX_SEG_W-1:0] GLYPH_F = 7'h71;

    // Nibble to active-high glyph lookup, handy for software-side models.
    function automatic logic [HEX_SEG_W-1:0] hex_glyph(input logic [3:0] nib);
        logic [HEX_SEG_W-1:0] g;
        case (nib)
            4'h0:    g = GLYPH_0;
            4'h1:    g = GLYPH_1;
            4'h2:    g = GLYPH_2;
            4'h3:    g = GLYPH_3;
            4'h4:    g = GLYPH_4;
            4'h5:    g = GLYPH_5;
            4'h6:    g = GLYPH_6;
            4'h7:    g = GLYPH_7;
            4'h8:    g = GLYPH_8;
            4'h9:    g = GLYPH_9;
            4'hA:    g = GLYPH_A;
            4'hB:    g = GLYPH_B;
            4'hC:    g = GLYPH_C;
            4'hD:    g = GLYPH_D;
            4'hE:    g = GLYPH_E;
            default: g = GLYPH_F;
        endcase
        return g;
    endfunction

endpackage

// File: rtl/hex_scan_driver.sv
// Time-multiplexed seven-segment scan driver. Captures the packed segment
// word once per frame into a shadow register, then walks the digits with a
// blanking gap followed by a PWM-gated dwell slot for each one. Every output
// is a flop computed from the next-state values so it reflects the state
// entered on the same edge.
module hex_scan_driver
    import hex_scan_pkg::*;
#(
    parameter int NUM_DIGITS   = 2,
    parameter int SEG_W        = HEX_SEG_W,
    parameter int DWELL_CYCLES = 50000,
    parameter int BLANK_CYCLES = 500,
    parameter int ACTIVE_LOW   = 1
) (
    input  logic                        clk,
    input  logic                        reset,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic                        enable,
    input  logic [3:0]                  bright,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       dig_en,
    output logic                        frame_start
);

    // One counter serves both BLANK and SHOW, so size it for the longer one.
    localparam int MAX_SLOT = (DWELL_CYCLES > BLANK_CYCLES) ? DWELL_CYCLES : BLANK_CYCLES;
    localparam int CNT_W    = $clog2(MAX_SLOT + 1);
    localparam int DIG_W    = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1;

    localparam logic [CNT_W-1:0] DWELL_LAST = CNT_W'(DWELL_CYCLES - 1);
    localparam logic [CNT_W-1:0] BLANK_LAST = CNT_W'(BLANK_CYCLES - 1);
    localparam logic [DIG_W-1:0] DIG_LAST   = DIG_W'(NUM_DIGITS - 1);

    // Pin inversion mask; XOR with it turns logical "lit" into pin level.
    localparam logic                  POL_INV  = (ACTIVE_LOW != 0);
    localparam logic [SEG_W-1:0]      SEG_OFF  = {SEG_W{POL_INV}};
    localparam logic [NUM_DIGITS-1:0] DIG_OFF  = {NUM_DIGITS{POL_INV}};

    // Sequencer state.
    scan_state_e                 state_q,  state_d;
    logic [CNT_W-1:0]            cnt_q,    cnt_d;
    logic [DIG_W-1:0]            digit_q,  digit_d;
    logic [3:0]                  pwm_q,    pwm_d;
    logic [NUM_DIGITS*SEG_W-1:0] shadow_q, shadow_d;

    // Registered outputs.
    logic [SEG_W-1:0]            seg_out_q,     seg_out_d;
    logic [NUM_DIGITS-1:0]       dig_en_q,      dig_en_d;
    logic                        frame_start_q, frame_start_d;

    // Per-digit views of the next shadow word and next digit index.
    logic [SEG_W-1:0]            digit_pat [NUM_DIGITS];
    logic [NUM_DIGITS-1:0]       digit_onehot;
    logic                        lit;

    for (genvar gi = 0; gi < NUM_DIGITS; gi++) begin : g_digit
        assign digit_pat[gi]    = shadow_d[gi*SEG_W +: SEG_W];
        assign digit_onehot[gi] = (digit_d == DIG_W'(gi));
    end

    // Next-state sequencing: enable low forces IDLE, otherwise walk
    // IDLE -> BLANK -> SHOW -> BLANK ... recapturing at each frame wrap.
    always_comb begin
        state_d       = state_q;
        cnt_d         = cnt_q;
        digit_d       = digit_q;
        pwm_d         = pwm_q;
        shadow_d      = shadow_q;
        frame_start_d = 1'b0;

        if (!enable) begin
            state_d = IDLE;
            cnt_d   = '0;
            digit_d = '0;
            pwm_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    state_d       = BLANK;
                    cnt_d         = '0;
                    digit_d       = '0;
                    shadow_d      = seg_in;
                    frame_start_d = 1'b1;
                end
                BLANK: begin
                    if (cnt_q == BLANK_LAST) begin
                        state_d = SHOW;
                        cnt_d   = '0;
                        pwm_d   = '0;
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                SHOW: begin
                    // Free-running 4-bit wrap gives the 16-step PWM period.
                    pwm_d = pwm_q + 4'd1;
                    if (cnt_q == DWELL_LAST) begin
                        state_d = BLANK;
                        cnt_d   = '0;
                        if (digit_q == DIG_LAST) begin
                            digit_d       = '0;
                            shadow_d      = seg_in;
                            frame_start_d = 1'b1;
                        end else begin
                            digit_d = digit_q + DIG_W'(1);
                        end
                    end else begin
                        cnt_d = cnt_q + CNT_W'(1);
                    end
                end
                default: begin
                    state_d = IDLE;
                    cnt_d   = '0;
                    digit_d = '0;
                    pwm_d   = '0;
                end
            endcase
        end
    end

    // Output decode from next-state values; bright is used live, unshadowed.
    always_comb begin
        lit       = (state_d == SHOW) && ((bright == 4'hF) || (pwm_d < bright));
        seg_out_d = SEG_OFF;
        dig_en_d  = DIG_OFF;
        if (lit) begin
            seg_out_d = digit_pat[digit_d] ^ SEG_OFF;
            dig_en_d  = digit_onehot ^ DIG_OFF;
        end
    end

    // State and output registers with synchronous reset to the off level.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= IDLE;
            cnt_q         <= '0;
            digit_q       <= '0;
            pwm_q         <= '0;
            shadow_q      <= '0;
            seg_out_q     <= SEG_OFF;
            dig_en_q      <= DIG_OFF;
            frame_start_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            digit_q       <= digit_d;
            pwm_q         <= pwm_d;
            shadow_q      <= shadow_d;
            seg_out_q     <= seg_out_d;
            dig_en_q      <= dig_en_d;
            frame_start_q <= frame_start_d;
        end
    end

    assign seg_out     = seg_out_q;
    assign dig_en      = dig_en_q;
    assign frame_start = frame_start_q;

endmodule

// File: tb/tb_hex_scan_driver.sv
// Self-checking bench for hex_scan_driver (2 digits, dwell 20, blank 3,
// active-low pins). A frame-position reference model predicts every output
// cycle; directed sequences and a brightness table cover the corner cases.
module tb_hex_scan_driver;

    localparam int ND    = 2;
    localparam int SW    = 7;
    localparam int DW    = 20;
    localparam int BW    = 3;
    localparam int SLOT  = BW + DW;
    localparam int FRAME = ND * SLOT;

    logic              clk = 1'b0;
    logic              reset;
    logic              enable;
    logic [ND*SW-1:0]  seg_in;
    logic [3:0]        bright;
    logic [SW-1:0]     seg_out;
    logic [ND-1:0]     dig_en;
    logic              frame_start;

    always #5 clk = ~clk;

    hex_scan_driver #(
        .NUM_DIGITS  (ND),
        .SEG_W       (SW),
        .DWELL_CYCLES(DW),
        .BLANK_CYCLES(BW),
        .ACTIVE_LOW  (1)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .seg_in     (seg_in),
        .enable     (enable),
        .bright     (bright),
        .seg_out    (seg_out),
        .dig_en     (dig_en),
        .frame_start(frame_start)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    endtask

    // Reference model: position within the frame since the last capture.
    bit            m_active = 1'b0;
    int            m_pos    = 0;
    logic [ND*SW-1:0] m_shadow = '0;
    logic          e_fs;
    logic [SW-1:0] e_seg;
    logic [ND-1:0] e_dig;

    task automatic model_step();
        int digit, slot, k;
        logic lit;
        logic [SW-1:0] pat;
        e_fs = 1'b0;
        if (reset) begin
            m_active = 1'b0;
            m_shadow = '0;
        end else if (!enable) begin
            m_active = 1'b0;
        end else if (!m_active) begin
            m_active = 1'b1;
            m_pos    = 0;
            m_shadow = seg_in;
            e_fs     = 1'b1;
        end else begin
            m_pos++;
            if (m_pos == FRAME) begin
                m_pos    = 0;
                m_shadow = seg_in;
                e_fs     = 1'b1;
            end
        end
        digit = m_pos / SLOT;
        slot  = m_pos % SLOT;
        lit   = 1'b0;
        if (m_active && slot >= BW) begin
            k   = slot - BW;
            lit = (bright == 4'd15) || ((k % 16) < int'(bright));
        end
        pat   = m_shadow[digit*SW +: SW];
        e_seg = lit ? ~pat : 7'h7F;
        e_dig = lit ? ~(ND'(1) << digit) : 2'b11;
    endtask

    // One clock: model consumes the inputs sampled at the edge, then compare.
    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        check("seg_out", 32'(seg_out), 32'(e_seg));
        check("dig_en", 32'(dig_en), 32'(e_dig));
        check("frame_start", 32'(frame_start), 32'(e_fs));
        check("dig_onehot", 32'($countones(~dig_en) <= 1), 32'd1);
    endtask

    // Lit-cycle statistics per digit with an expected pin pattern each.
    int            lit_cnt [ND];
    int            bad_pat;
    logic [SW-1:0] want_pat [ND];

    task automatic clear_stats();
        lit_cnt[0] = 0;
        lit_cnt[1] = 0;
        bad_pat    = 0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) begin
            tick();
            if (dig_en == 2'b10) begin
                lit_cnt[0]++;
                if (seg_out !== want_pat[0]) bad_pat++;
            end else if (dig_en == 2'b01) begin
                lit_cnt[1]++;
                if (seg_out !== want_pat[1]) bad_pat++;
            end
        end
    endtask

    // Pass through IDLE so the next edge is a fresh frame capture.
    task automatic restart(input logic [ND*SW-1:0] s, input logic [3:0] b);
        enable = 1'b0;
        tick();
        seg_in = s;
        bright = b;
        enable = 1'b1;
        tick();
        check("restart_fs", 32'(frame_start), 32'd1);
    endtask

    typedef struct {
        logic [3:0]       b;
        logic [ND*SW-1:0] s;
        int               lit0;
        int               lit1;
        logic [SW-1:0]    pin0;
        logic [SW-1:0]    pin1;
    } vec_t;

    vec_t vecs [6];

    initial begin
        int first_lit, period;

        // Digit 0 = '5' (6D), digit 1 = 'A' (77) -> pins 12 / 08.
        vecs[0] = '{4'd4,  {7'h77, 7'h6D}, 8,  8,  7'h12, 7'h08};
        vecs[1] = '{4'd0,  {7'h77, 7'h6D}, 0,  0,  7'h12, 7'h08};
        vecs[2] = '{4'd15, 14'h033F,       20, 20, 7'h40, 7'h79};
        vecs[3] = '{4'd1,  14'h033F,       2,  2,  7'h40, 7'h79};
        vecs[4] = '{4'd8,  {7'h77, 7'h6D}, 12, 12, 7'h12, 7'h08};
        vecs[5] = '{4'd14, 14'h033F,       18, 18, 7'h40, 7'h79};

        // Reset held two cycles with enable high.
        reset  = 1'b1;
        enable = 1'b1;
        seg_in = 14'h033F;
        bright = 4'd15;
        tick();
        tick();
        check("rst_seg", 32'(seg_out), 32'h7F);
        check("rst_dig", 32'(dig_en), 32'h3);
        check("rst_fs", 32'(frame_start), 32'd0);
        $display("[reset] held 2 cycles seg=%h dig=%b fs=%b", seg_out, dig_en, frame_start);
        reset = 1'b0;
        tick();
        check("rel_fs", 32'(frame_start), 32'd1);
        check("rel_seg", 32'(seg_out), 32'h7F);
        $display("[reset] released fs=%b seg=%h", frame_start, seg_out);

        // Basic scan timing and frame period.
        want_pat[0] = 7'h40;
        want_pat[1] = 7'h79;
        clear_stats();
        first_lit = -1;
        for (int i = 1; i < FRAME; i++) begin
            run(1);
            if (first_lit < 0 && dig_en != 2'b11) first_lit = i;
        end
        check("scan_first_lit", 32'(first_lit), 32'd3);
        check("scan_lit0", 32'(lit_cnt[0]), 32'd20);
        check("scan_lit1", 32'(lit_cnt[1]), 32'd20);
        check("scan_pat", 32'(bad_pat), 32'd0);
        period = 0;
        for (int i = 0; i < 2 * FRAME && period == 0; i++) begin
            tick();
            if (frame_start) period = FRAME + i;
        end
        check("frame_period", 32'(period), 32'd46);
        $display("[scan] first_lit=%0d lit=%0d/%0d period=%0d", first_lit, lit_cnt[0], lit_cnt[1], period);

        // Brightness table: one full frame per record.
        for (int v = 0; v < 6; v++) begin
            restart(vecs[v].s, vecs[v].b);
            want_pat[0] = vecs[v].pin0;
            want_pat[1] = vecs[v].pin1;
            clear_stats();
            run(FRAME - 1);
            check("pwm_lit0", 32'(lit_cnt[0]), 32'(vecs[v].lit0));
            check("pwm_lit1", 32'(lit_cnt[1]), 32'(vecs[v].lit1));
            check("pwm_pat", 32'(bad_pat), 32'd0);
            $display("[pwm] bright=%0d lit0=%0d lit1=%0d bad_pat=%0d", vecs[v].b, lit_cnt[0], lit_cnt[1], bad_pat);
        end

        // Tear-free: seg_in changes during digit 0 SHOW.
        restart(14'h033F, 4'd15);
        want_pat[0] = 7'h40;
        want_pat[1] = 7'h79;
        clear_stats();
        run(BW + 5);
        seg_in = 14'h3FFF;
        run(FRAME - 1 - (BW + 5));
        check("tear_lit1", 32'(lit_cnt[1]), 32'd20);
        check("tear_pat", 32'(bad_pat), 32'd0);
        tick();
        check("tear_fs", 32'(frame_start), 32'd1);
        want_pat[0] = 7'h00;
        want_pat[1] = 7'h00;
        clear_stats();
        run(FRAME - 1);
        check("tear_next_lit0", 32'(lit_cnt[0]), 32'd20);
        check("tear_next_lit1", 32'(lit_cnt[1]), 32'd20);
        check("tear_next_pat", 32'(bad_pat), 32'd0);
        $display("[tear] next frame lit=%0d/%0d bad_pat=%0d", lit_cnt[0], lit_cnt[1], bad_pat);

        // enable dropped at SHOW cycle 10, then re-enabled with new word.
        restart(14'h033F, 4'd15);
        run(BW - 1 + 10);
        check("en_pre_dig", 32'(dig_en), 32'h2);
        enable = 1'b0;
        tick();
        check("en_off_seg", 32'(seg_out), 32'h7F);
        check("en_off_dig", 32'(dig_en), 32'h3);
        seg_in = {7'h5B, 7'h06};
        enable = 1'b1;
        tick();
        check("en_re_fs", 32'(frame_start), 32'd1);
        run(BW - 1);
        check("en_blank_dig", 32'(dig_en), 32'h3);
        tick();
        check("en_first_seg", 32'(seg_out), 32'h79);
        check("en_first_dig", 32'(dig_en), 32'h2);
        $display("[enable] restart seg=%h dig=%b", seg_out, dig_en);

        // reset mid-SHOW of digit 1.
        restart(14'h033F, 4'd15);
        run(SLOT + BW + 4);
        check("rs_pre_dig", 32'(dig_en), 32'h1);
        reset = 1'b1;
        tick();
        check("rs_off_seg", 32'(seg_out), 32'h7F);
        check("rs_off_dig", 32'(dig_en), 32'h3);
        check("rs_off_fs", 32'(frame_start), 32'd0);
        reset = 1'b0;
        tick();
        check("rs_rel_fs", 32'(frame_start), 32'd1);
        run(BW - 1);
        tick();
        check("rs_restart_dig", 32'(dig_en), 32'h2);
        $display("[reset-mid] restart dig=%b seg=%h", dig_en, seg_out);

        // Randomized traffic against the reference model.
        for (int blk = 0; blk < 30; blk++) begin
            for (int i = 0; i < 100; i++) begin
                reset = ($urandom_range(0, 399) == 0);
                if (enable && $urandom_range(0, 249) == 0) enable = 1'b0;
                else if (!enable && $urandom_range(0, 7) == 0) enable = 1'b1;
                if ($urandom_range(0, 29) == 0) bright = 4'($urandom_range(0, 15));
                if ($urandom_range(0, 39) == 0) seg_in = 14'($urandom);
                tick();
            end
            $display("[random] block %0d en=%b bright=%0d seg_in=%h", blk, enable, bright, seg_in);
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
